// File: rtl/kf6845_address_generator_if.sv
// Refresh-address bus between the CRTC timing stages and the MA generator.
// master drives timing and register values; slave returns MA, row start and cursor match.
interface kf6845_address_generator_if #(
  parameter int MA_WIDTH = 14,
  parameter int HD_WIDTH = 8
);
  logic                video_clock_enable;
  logic [MA_WIDTH-1:0] start_address;
  logic [HD_WIDTH-1:0] horizontal_displayed;
  logic                horizontal_end;
  logic                last_raster_of_row;
  logic                frame_end;
  logic [MA_WIDTH-1:0] cursor_address;
  logic [MA_WIDTH-1:0] MA;
  logic [MA_WIDTH-1:0] row_start_address;
  logic                cursor_match;

  modport master (
    output video_clock_enable, start_address, horizontal_displayed,
           horizontal_end, last_raster_of_row, frame_end, cursor_address,
    input  MA, row_start_address, cursor_match
  );

  modport slave (
    input  video_clock_enable, start_address, horizontal_displayed,
           horizontal_end, last_raster_of_row, frame_end, cursor_address,
    output MA, row_start_address, cursor_match
  );
endinterface

// File: rtl/kf6845_address_generator.sv
// KF6845 refresh memory address generator: row start tracking plus per-character MA count.
// Optional registered cursor compare is built when KF6845_CURSOR_MATCH_EN is defined.
module kf6845_address_generator #(
  parameter int MA_WIDTH = 14,
  parameter int HD_WIDTH = 8
) (
  input  logic clock,
  input  logic reset,
  kf6845_address_generator_if.slave bus
);

  logic [MA_WIDTH-1:0] ma_reg;
  logic [MA_WIDTH-1:0] ma_next;
  logic [MA_WIDTH-1:0] row_start_reg;
  logic [MA_WIDTH-1:0] row_start_next;
  logic [MA_WIDTH-1:0] row_sum;

  // Single adder shared by the row-start register and MA on a row advance.
  assign row_sum = row_start_reg + MA_WIDTH'(bus.horizontal_displayed);

  always_comb begin
    ma_next        = ma_reg;
    row_start_next = row_start_reg;
    if (bus.video_clock_enable) begin
      if (bus.horizontal_end && bus.frame_end) begin
        row_start_next = bus.start_address;
        ma_next        = bus.start_address;
      end else if (bus.horizontal_end && bus.last_raster_of_row) begin
        row_start_next = row_sum;
        ma_next        = row_sum;
      end else if (bus.horizontal_end) begin
        ma_next        = row_start_reg;
      end else begin
        ma_next        = ma_reg + MA_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ma_reg        <= '0;
      row_start_reg <= '0;
    end else begin
      ma_reg        <= ma_next;
      row_start_reg <= row_start_next;
    end
  end

  assign bus.MA                = ma_reg;
  assign bus.row_start_address = row_start_reg;

`ifdef KF6845_CURSOR_MATCH_EN
  logic [MA_WIDTH-1:0] bit_equal;
  logic                cursor_match_reg;

  generate
    for (genvar gi = 0; gi < MA_WIDTH; gi++) begin : g_cmp
      assign bit_equal[gi] = ~(ma_reg[gi] ^ bus.cursor_address[gi]);
    end
  endgenerate

  // Compare runs every clock, so the match flag lags MA by exactly one clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cursor_match_reg <= 1'b0;
    else       cursor_match_reg <= &bit_equal;
  end

  assign bus.cursor_match = cursor_match_reg;
`else
  logic unused_cursor;
  assign unused_cursor    = ^bus.cursor_address;
  assign bus.cursor_match = 1'b0;
`endif

endmodule

// File: tb/tb_kf6845_address_generator.sv
// Self-checking bench for kf6845_address_generator: reference model feeds a scoreboard queue.
module tb_kf6845_address_generator;
  localparam int MW = 14;

  typedef struct packed {
    logic [MW-1:0] ma;
    logic [MW-1:0] rs;
    logic          cm;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad   = 0;

  exp_t          sb[$];
  logic [MW-1:0] ma_m = '0;
  logic [MW-1:0] rs_m = '0;

  kf6845_address_generator_if #(.MA_WIDTH(MW), .HD_WIDTH(8)) bus ();

  kf6845_address_generator #(.MA_WIDTH(MW), .HD_WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock: drive controls, push model result, then pop and compare after the edge.
  task automatic step(input logic en, input logic he, input logic lr, input logic fe);
    exp_t e;
    logic cm_exp;
    @(negedge clock);
    bus.video_clock_enable = en;
    bus.horizontal_end     = he;
    bus.last_raster_of_row = lr;
    bus.frame_end          = fe;
`ifdef KF6845_CURSOR_MATCH_EN
    cm_exp = (ma_m == bus.cursor_address);
`else
    cm_exp = 1'b0;
`endif
    if (en) begin
      if (he && fe) begin
        rs_m = bus.start_address;
        ma_m = bus.start_address;
      end else if (he && lr) begin
        rs_m = rs_m + {6'd0, bus.horizontal_displayed};
        ma_m = rs_m;
      end else if (he) begin
        ma_m = rs_m;
      end else begin
        ma_m = ma_m + 14'd1;
      end
    end
    sb.push_back('{ma: ma_m, rs: rs_m, cm: cm_exp});
    @(posedge clock);
    #1;
    e = sb.pop_front();
    expect_eq("ma", 32'(bus.MA), 32'(e.ma));
    expect_eq("row_start", 32'(bus.row_start_address), 32'(e.rs));
    expect_eq("cursor_match", 32'(bus.cursor_match), 32'(e.cm));
    $display("step en=%0b he=%0b lr=%0b fe=%0b MA=%h rs=%h cm=%0b",
             en, he, lr, fe, bus.MA, bus.row_start_address, bus.cursor_match);
  endtask

  initial begin
    bus.video_clock_enable   = 1'b0;
    bus.start_address        = '0;
    bus.horizontal_displayed = 8'd80;
    bus.horizontal_end       = 1'b0;
    bus.last_raster_of_row   = 1'b0;
    bus.frame_end            = 1'b0;
    bus.cursor_address       = 14'h0005;
    repeat (2) @(posedge clock);
    #1;
    expect_eq("reset_ma", 32'(bus.MA), 32'h0);
    expect_eq("reset_rs", 32'(bus.row_start_address), 32'h0);
    expect_eq("reset_cm", 32'(bus.cursor_match), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // Free count from 0 with idle cycles between ticks; cursor at 5.
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1);
    expect_eq("disabled_hold", 32'(bus.MA), 32'h7);

    // Frame load then count.
    bus.start_address = 14'h0100;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    expect_eq("frame_load", 32'(bus.MA), 32'h0100);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_eq("count_after_load", 32'(bus.MA), 32'h0103);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    expect_eq("line_restart", 32'(bus.MA), 32'h0100);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    expect_eq("row_advance", 32'(bus.MA), 32'h0150);
    expect_eq("row_advance_rs", 32'(bus.row_start_address), 32'h0150);

    // Row start wrap.
    bus.start_address = 14'h3FD0;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    expect_eq("row_wrap", 32'(bus.MA), 32'h0020);

    // MA wrap.
    bus.start_address = 14'h3FFA;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_eq("ma_wrap", 32'(bus.MA), 32'h0000);

    // Frame wins over row advance; mid-frame start changes wait for frame_end.
    bus.start_address = 14'h03AA;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    expect_eq("frame_wins", 32'(bus.MA), 32'h03AA);
    bus.start_address = 14'h0200;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    expect_eq("midframe_ignored", 32'(bus.MA), 32'h03AA);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    expect_eq("midframe_row", 32'(bus.MA), 32'h03FA);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    expect_eq("next_frame", 32'(bus.MA), 32'h0200);

    // Asynchronous reset mid-line clears without waiting for an edge.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    bus.video_clock_enable = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    expect_eq("async_reset_ma", 32'(bus.MA), 32'h0);
    expect_eq("async_reset_rs", 32'(bus.row_start_address), 32'h0);
    ma_m = '0;
    rs_m = '0;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_eq("resume_count", 32'(bus.MA), 32'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/kf6845_address_generator.md
Name: kf6845_address_generator

Overview:
- Refresh memory address (MA) generator for the KF6845 CRTC.
- Produces the 14-bit MA bus consumed by the light pen latch, the cursor logic and the external video memory.
- Tracks a row start address that advances by R1 (horizontal displayed) at each character-row boundary and reloads from R12/R13 (start address) at each frame boundary.
- Advances only on video_clock_enable ticks, which are character clocks, driven by the horizontal/vertical timing stages.

Parameters:
- MA_WIDTH, 14, width of MA, start_address, cursor_address and the internal row start register.
- HD_WIDTH, 8, width of horizontal_displayed.

Ports:
- clock  input  1  system clock.
- reset  input  1  reset, asynchronous, active-high.
- video_clock_enable  input  1  one-cycle character clock enable; all state advances only when high.
- start_address  input  MA_WIDTH  R12/R13 display start address; sampled only at frame boundary.
- horizontal_displayed  input  HD_WIDTH  R1; zero-extended and added to the row start.
- horizontal_end  input  1  high during the last character of a scan line (h counter == R0).
- last_raster_of_row  input  1  high during the last scan line of a character row (raster == R9).
- frame_end  input  1  high during the last scan line of the frame, including vertical adjust.
- cursor_address  input  MA_WIDTH  R14/R15; used only when the optional feature is enabled.
- MA  output  MA_WIDTH  current refresh memory address, registered.
- row_start_address  output  MA_WIDTH  address of the first character of the current row, registered.
- cursor_match  output  1  MA equals cursor_address, registered; constant 0 when the feature is disabled.

Behaviour:
- Reset (async, active-high): MA = 0, row_start_address = 0, cursor_match = 0. Release is synchronous to clock.
- No state change on any cycle where video_clock_enable = 0.
- On each enabled tick, conditions are evaluated in priority order:
  1. horizontal_end && frame_end: row_start_address <= start_address; MA <= start_address.
  2. horizontal_end && last_raster_of_row: row_start_address <= row_start_address + horizontal_displayed; MA <= that same sum (one adder output feeds both registers).
  3. horizontal_end only: MA <= row_start_address; row_start_address unchanged.
  4. Otherwise: MA <= MA + 1.
- frame_end without horizontal_end has no effect beyond rule 4.
- frame_end together with last_raster_of_row: frame_end wins, so start_address is loaded and the row advance is dropped.
- Arithmetic is modulo 2^MA_WIDTH. 14'h3FFF + 1 = 14'h0000. Row start advance wraps the same way.
- MA keeps incrementing through horizontal blanking; no clamp at horizontal_displayed.
- Latency: a condition present on enabled tick N is visible on MA after that clock edge. MA is stable for the whole character period.
- start_address changes mid-frame have no effect until the next frame boundary.
- cursor_match (feature on) is updated on every clock edge, not gated by video_clock_enable. It is the registered compare of the current MA register against cursor_address, so it lags MA by one clock.
- Reset asserted mid-line: outputs clear immediately. Counting resumes from 0 until the next frame boundary.

Optional Feature:
- Macro: KF6845_CURSOR_MATCH_EN.
- Defined: a 14-bit comparator and register drive cursor_match as described above.
- Undefined: no comparator is built; cursor_match is tied to 0 and cursor_address is unused.

Test Plan:
- Reset, then 5 enabled ticks with no control inputs -> MA = 0,1,2,3,4,5; row_start_address = 0; disabled cycles between ticks leave MA unchanged.
- start_address = 14'h0100, pulse horizontal_end + frame_end on one tick -> MA = 14'h0100, row_start_address = 14'h0100; next 3 ticks give 14'h0101..14'h0103.
- After row_start = 14'h0100, horizontal_displayed = 80, pulse horizontal_end only -> MA = 14'h0100. Then horizontal_end + last_raster_of_row -> MA = row_start_address = 14'h0150.
- row_start = 14'h3FD0, horizontal_displayed = 80, row advance -> MA = 14'h0020. MA = 14'h3FFF plus one tick -> 14'h0000.
- horizontal_end + last_raster_of_row + frame_end together with start_address = 14'h03AA -> MA = 14'h03AA (frame wins); changing start_address mid-frame to 14'h0200 has no effect until the next frame_end.
- With KF6845_CURSOR_MATCH_EN defined, cursor_address = 14'h0005, count from 0 -> cursor_match high exactly one clock after MA = 5, low otherwise. Without the macro, cursor_match stays 0.
